// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter in front of a single-ported data memory
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              p0_pend_q, p0_pend_d, p1_pend_q, p1_pend_d;
    logic              p0_err_q, p0_err_d, p1_err_q, p1_err_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic              last_q, last_d;

    logic              elig0, elig1, gnt0, gnt1, any_gnt, misal;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, cap_rdata;

    always_comb begin
        // A port may re-request in the same cycle its response drains.
        elig0 = rst_n & p0_req_valid & (~p0_pend_q | p0_rsp_ready);
        elig1 = rst_n & p1_req_valid & (~p1_pend_q | p1_rsp_ready);
        gnt0  = elig0 & (~elig1 | last_q);
        gnt1  = elig1 & (~elig0 | ~last_q);
        any_gnt = gnt0 | gnt1;

        sel_we    = gnt1 ? p1_req_we    : p0_req_we;
        sel_addr  = gnt1 ? p1_req_addr  : p0_req_addr;
        sel_wdata = gnt1 ? p1_req_wdata : p0_req_wdata;
        misal     = |sel_addr[1:0];

        mem_addr     = any_gnt ? sel_addr  : '0;
        mem_wdata    = any_gnt ? sel_wdata : '0;
        mem_read_en  = any_gnt & ~misal & ~sel_we;
        mem_write_en = any_gnt & ~misal & sel_we;
        cap_rdata    = mem_read_en ? mem_rdata : '0;

        p0_req_ready = gnt0;
        p1_req_ready = gnt1;

        p0_pend_d  = p0_pend_q & ~p0_rsp_ready;
        p0_rdata_d = p0_rdata_q;
        p0_err_d   = p0_err_q;
        if (gnt0) begin
            p0_pend_d  = 1'b1;
            p0_rdata_d = cap_rdata;
            p0_err_d   = misal;
        end

        p1_pend_d  = p1_pend_q & ~p1_rsp_ready;
        p1_rdata_d = p1_rdata_q;
        p1_err_d   = p1_err_q;
        if (gnt1) begin
            p1_pend_d  = 1'b1;
            p1_rdata_d = cap_rdata;
            p1_err_d   = misal;
        end

        last_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_pend_q  <= 1'b0;
            p1_pend_q  <= 1'b0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            last_q     <= 1'b1;
        end else begin
            p0_pend_q  <= p0_pend_d;
            p1_pend_q  <= p1_pend_d;
            p0_err_q   <= p0_err_d;
            p1_err_q   <= p1_err_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            last_q     <= last_d;
        end
    end

    assign p0_rsp_valid = p0_pend_q;
    assign p0_rsp_rdata = p0_rdata_q;
    assign p0_rsp_err   = p0_err_q;
    assign p1_rsp_valid = p1_pend_q;
    assign p1_rsp_rdata = p1_rdata_q;
    assign p1_rsp_err   = p1_err_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the single-ported data memory (word-addressed, combinational read, write on rising clock edge). It grants one requester per cycle using round-robin arbitration. Port 0 is the core load/store unit. Port 1 is the debug/program-loader port. Each port receives a registered response with valid/ready back-pressure, and the arbiter rejects misaligned accesses without touching memory.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width; word = DATA_W/8 bytes, word alignment checked on addr[1:0]
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- p0_req_valid / p1_req_valid  in  1  request present
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle when valid&ready
- p0_req_we / p1_req_we  in  1  1 = store, 0 = load
- p0_req_addr / p1_req_addr  in  ADDR_W  byte address
- p0_req_wdata / p1_req_wdata  in  DATA_W  store data
- p0_rsp_valid / p1_rsp_valid  out  1  response held until ready
- p0_rsp_ready / p1_rsp_ready  in  1  response consumed when valid&ready
- p0_rsp_rdata / p1_rsp_rdata  out  DATA_W  load data; 0 for stores and errors
- p0_rsp_err / p1_rsp_err  out  1  1 = misaligned request, no memory access performed
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write data
- mem_read_en  out  1  to memory read enable
- mem_write_en  out  1  to memory write enable
- mem_rdata  in  DATA_W  from memory, combinational in same cycle

## Operation
- Per-port state: pend_q (response outstanding), rsp_rdata_q, rsp_err_q, rsp_we_q. Global state: last_q (index of last granted port).
- Eligibility of port i: req_valid_i and (!pend_q_i or (rsp_valid_i and rsp_ready_i)). A port is eligible in the same cycle its response drains, which allows back-to-back requests from one port.
- Arbitration:
  - One eligible port: that port is granted.
  - Both ports eligible: grant the port != last_q.
  - last_q updates to the granted index on each grant.
- req_ready_i is 1 only for the granted port. It is combinational from req_valid, pend_q, rsp_valid and rsp_ready.
- Grant of an aligned request (addr[1:0]==0):
  - mem_addr = req_addr and mem_wdata = req_wdata of the winner.
  - mem_read_en = !we and mem_write_en = we.
  - The memory commits a store at the end of the grant cycle.
- Grant of a misaligned request (addr[1:0]!=0): mem_read_en and mem_write_en stay 0. The response carries err=1 and rdata=0.
- No grant: mem_read_en = mem_write_en = 0, and mem_addr/mem_wdata = 0.
- Response capture at the edge ending the grant cycle:
  - pend_q_i set to 1.
  - rsp_rdata_q_i = mem_rdata for an aligned load, otherwise 0.
  - rsp_err_q_i set to the misalignment flag.
- pend_q_i clears on rsp_valid_i & rsp_ready_i unless a new grant to port i occurs in the same cycle; a new grant sets it again.
- rsp_valid_i = pend_q_i. Response outputs are driven directly from registers.
- Stores also produce a response (write acknowledge) with rdata=0.

## Timing
- Reset (rst_n=0 sampled at rising edge):
  - pend_q=0, all rsp_* outputs 0, rsp_rdata_q=0, last_q=1 (port 0 wins the first tie).
  - While rst_n=0: req_ready=0 on both ports, mem enables 0, and no grant is issued.
- Latency: request accepted in cycle N gives rsp_valid=1 in cycle N+1. The load value is the memory contents in cycle N, so a same-cycle store by the other port cannot occur because there is only one grant per cycle.
- Throughput:
  - 1 access per cycle aggregate.
  - 1 per cycle per port if rsp_ready is held high.
  - A port with a response pending and rsp_ready=0 has req_ready=0.
- A stalled response (rsp_ready=0) holds rsp_valid, rsp_rdata and rsp_err stable. The other port continues to be served.
- Read-after-write through the arbiter:
  - A store granted in cycle N followed by a load granted in cycle N+1 returns the new data.
  - A load and a store to the same address contending in one cycle are serialized in round-robin order.
- Reset mid-operation: outstanding responses are dropped (rsp_valid=0 the cycle after the reset edge). A store granted in the cycle in which rst_n=0 is sampled is not issued, because no grants are made during reset.

## Test plan
- Reset, then p0 load addr 0x8 with memory = 0xDEADBEEF → p0_req_ready=1 in cycle N, p0_rsp_valid=1 and p0_rsp_rdata=0xDEADBEEF in cycle N+1, p0_rsp_err=0.
- p1 store 0x12345678 to 0x10 in cycle N, then p0 load 0x10 in cycle N+1 → p1 rsp (rdata=0, err=0) at N+1, p0 rsp rdata=0x12345678 at N+2.
- Both ports issue continuous loads with rsp_ready=1 for 6 cycles after reset → grants p0,p1,p0,p1,p0,p1, one per cycle, with mem_read_en=1 every cycle.
- p0 load to 0x6 → no mem enables that cycle, p0_rsp_err=1 and rdata=0 next cycle, memory unchanged.
- p0 rsp_ready held 0 for 4 cycles with p0 and p1 both requesting → p0_req_ready=0 and p0 response stable throughout, p1 granted every cycle; p0 is re-granted in the cycle rsp_ready rises.
- rst_n driven low while p1 has a pending response and p0 is requesting a store → next cycle p1_rsp_valid=0, no mem_write_en while reset is low, last_q=1 after release.
